// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port shared memory with round-robin
// tie-breaking and bounded lock bursts that are broken after LOCK_MAX grants.
module mem_arbiter #(
  parameter int DEPTH    = 32,
  parameter int BITS     = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic                     a_lock,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [BITS-1:0]          a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [BITS-1:0]          a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic                     b_lock,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [BITS-1:0]          b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [BITS-1:0]          b_rdata,
  output logic [$clog2(DEPTH)-1:0] mem_address,
  output logic [BITS-1:0]          mem_writeData,
  output logic                     mem_writeEn,
  input  logic [BITS-1:0]          mem_readData,
  output logic                     lock_timeout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;

  state_t          r_state, w_nextState;
  logic [CW-1:0]   r_cnt, w_nextCnt, w_cntInc;
  logic            r_last, w_nextLast;
  logic            r_aRvalid, r_bRvalid;
  logic            w_aGnt, w_bGnt, w_timeout;

  // r_last is 1 when B was granted most recently, so A wins the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_aRvalid <= 1'b0;
      r_bRvalid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_last    <= w_nextLast;
      r_aRvalid <= w_aGnt & ~a_we;
      r_bRvalid <= w_bGnt & ~b_we;
    end
  end

  always_comb begin
    w_aGnt = 1'b0;
    w_bGnt = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ARB: begin
          if (a_req && b_req) begin
            w_aGnt = r_last;
            w_bGnt = ~r_last;
          end else begin
            w_aGnt = a_req;
            w_bGnt = b_req;
          end
        end
        LOCK_A:  w_aGnt = a_req;
        LOCK_B:  w_bGnt = b_req;
        default: ;
      endcase
    end
  end

  // The counter never passes CNT_MAX; reaching it ends the burst
  assign w_cntInc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextLast  = r_last;
    w_timeout   = 1'b0;
    if (w_aGnt) w_nextLast = 1'b0;
    if (w_bGnt) w_nextLast = 1'b1;
    unique case (r_state)
      ARB: begin
        if (w_aGnt && a_lock) begin
          w_nextState = LOCK_A;
          w_nextCnt   = CNT_ONE;
        end else if (w_bGnt && b_lock) begin
          w_nextState = LOCK_B;
          w_nextCnt   = CNT_ONE;
        end
      end
      LOCK_A: begin
        if (!a_req || !a_lock) begin
          w_nextState = ARB;
        end else begin
          w_nextCnt = w_cntInc;
          if (w_cntInc == CNT_MAX) begin
            w_timeout   = 1'b1;
            w_nextState = ARB;
          end
        end
      end
      LOCK_B: begin
        if (!b_req || !b_lock) begin
          w_nextState = ARB;
        end else begin
          w_nextCnt = w_cntInc;
          if (w_cntInc == CNT_MAX) begin
            w_timeout   = 1'b1;
            w_nextState = ARB;
          end
        end
      end
      default: w_nextState = ARB;
    endcase
  end

  assign a_gnt         = w_aGnt;
  assign b_gnt         = w_bGnt;
  assign lock_timeout  = w_timeout;
  assign mem_address   = w_aGnt ? a_addr  : (w_bGnt ? b_addr  : '0);
  assign mem_writeData = w_aGnt ? a_wdata : (w_bGnt ? b_wdata : '0);
  assign mem_writeEn   = (w_aGnt & a_we) | (w_bGnt & b_we);
  assign a_rvalid      = r_aRvalid;
  assign b_rvalid      = r_bRvalid;
  assign a_rdata       = r_aRvalid ? mem_readData : '0;
  assign b_rdata       = r_bRvalid ? mem_readData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written lock/timeout/reset
// sequences, then constrained-random traffic checked against a behavioural model.
module tb_mem_arbiter;

  localparam int DEPTH    = 32;
  localparam int BITS     = 64;
  localparam int LOCK_MAX = 16;

  typedef struct packed {
    logic        rstN;
    logic        aReq, aWe, aLock;
    logic [4:0]  aAddr;
    logic [63:0] aWdata;
    logic        bReq, bWe, bLock;
    logic [4:0]  bAddr;
    logic [63:0] bWdata;
  } stimT;

  typedef struct packed {
    logic        aGnt, bGnt, aRvalid, bRvalid, memWe, timeout;
    logic [4:0]  memAddr;
    logic [63:0] memWdata, aRdata, bRdata;
  } outT;

  typedef struct {
    stimT s;
    outT  e;
  } vecT;

  logic        clk, rst_n;
  logic        a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic        b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [4:0]  a_addr, b_addr, mem_address;
  logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_writeData, mem_readData;
  logic        mem_writeEn, lock_timeout;

  int passCount = 0;
  int checkCount = 0;
  bit useModel = 0;
  outT act, exp;

  // Reference model state
  int owner, lockRun, lastWin;
  bit pendA, pendB;
  logic [63:0] pendAData, pendBData;
  logic [63:0] refMem [32];
  logic [63:0] memArr [32];

  mem_arbiter #(.DEPTH(DEPTH), .BITS(BITS), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_writeEn(mem_writeEn),
    .mem_readData(mem_readData), .lock_timeout(lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: writes land at negedge, reads are registered at posedge
  initial begin
    for (int i = 0; i < 32; i++) memArr[i] = '0;
    forever begin
      @(negedge clk);
      if (mem_writeEn) memArr[mem_address] = mem_writeData;
    end
  end
  always @(posedge clk) mem_readData <= memArr[mem_address];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stimT mk(bit r, bit ar, bit aw, bit al, logic [4:0] aa, logic [63:0] ad,
                              bit br, bit bw, bit bl, logic [4:0] ba, logic [63:0] bd);
    stimT s;
    s.rstN = r; s.aReq = ar; s.aWe = aw; s.aLock = al; s.aAddr = aa; s.aWdata = ad;
    s.bReq = br; s.bWe = bw; s.bLock = bl; s.bAddr = ba; s.bWdata = bd;
    return s;
  endfunction

  function automatic outT ex(bit ag, bit bg, bit arv, bit brv, bit we, bit to,
                             logic [4:0] ad, logic [63:0] wd, logic [63:0] ard, logic [63:0] brd);
    outT o;
    o.aGnt = ag; o.bGnt = bg; o.aRvalid = arv; o.bRvalid = brv; o.memWe = we; o.timeout = to;
    o.memAddr = ad; o.memWdata = wd; o.aRdata = ard; o.bRdata = brd;
    return o;
  endfunction

  // Winner: 0 none, 1 A, 2 B; a lock owner excludes the other side
  function automatic int modelWinner(stimT s);
    int win = 0;
    if (s.rstN) begin
      if (owner == 1) win = s.aReq ? 1 : 0;
      else if (owner == 2) win = s.bReq ? 2 : 0;
      else if (s.aReq && s.bReq) win = 3 - lastWin;
      else if (s.aReq) win = 1;
      else if (s.bReq) win = 2;
    end
    return win;
  endfunction

  function automatic outT modelOut(stimT s, int win);
    outT o;
    o = '0;
    if (s.rstN) begin
      o.aGnt = (win == 1);
      o.bGnt = (win == 2);
      if (win == 1) begin o.memAddr = s.aAddr; o.memWdata = s.aWdata; o.memWe = s.aWe; end
      if (win == 2) begin o.memAddr = s.bAddr; o.memWdata = s.bWdata; o.memWe = s.bWe; end
      o.aRvalid = pendA;
      o.bRvalid = pendB;
      o.aRdata  = pendA ? pendAData : 64'd0;
      o.bRdata  = pendB ? pendBData : 64'd0;
      if (win != 0 && win == owner)
        o.timeout = ((win == 1) ? s.aLock : s.bLock) && (lockRun + 1 >= LOCK_MAX);
    end
    return o;
  endfunction

  task automatic modelUpdate(input stimT s, input int win);
    bit reqO, lockO;
    if (!s.rstN) begin
      owner = 0; lockRun = 0; lastWin = 2; pendA = 0; pendB = 0;
    end else begin
      pendA = (win == 1) && !s.aWe;
      pendB = (win == 2) && !s.bWe;
      pendAData = refMem[s.aAddr];
      pendBData = refMem[s.bAddr];
      if (win == 1 && s.aWe) refMem[s.aAddr] = s.aWdata;
      if (win == 2 && s.bWe) refMem[s.bAddr] = s.bWdata;
      if (owner != 0) begin
        reqO  = (owner == 1) ? s.aReq  : s.bReq;
        lockO = (owner == 1) ? s.aLock : s.bLock;
        if (!reqO || !lockO) owner = 0;
        else begin
          lockRun++;
          if (lockRun >= LOCK_MAX) owner = 0;
        end
      end else if (win == 1 && s.aLock) begin
        owner = 1; lockRun = 1;
      end else if (win == 2 && s.bLock) begin
        owner = 2; lockRun = 1;
      end
      if (win != 0) lastWin = win;
    end
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input stimT s);
    int win;
    @(posedge clk);
    #1;
    rst_n = s.rstN;
    a_req = s.aReq; a_we = s.aWe; a_lock = s.aLock; a_addr = s.aAddr; a_wdata = s.aWdata;
    b_req = s.bReq; b_we = s.bWe; b_lock = s.bLock; b_addr = s.bAddr; b_wdata = s.bWdata;
    #3;
    act = {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_writeEn, lock_timeout,
           mem_address, mem_writeData, a_rdata, b_rdata};
    win = modelWinner(s);
    exp = modelOut(s, win);
    if (useModel) checkOutput("model", 256'(act), 256'(exp));
    modelUpdate(s, win);
  endtask

  initial begin
    vecT  vecs [12];
    stimT idle, rs;
    bit   aBusy, bBusy;
    logic [63:0] beef;

    beef = 64'hDEADBEEF;
    idle = mk(1, 0,0,0,5'd0,64'd0, 0,0,0,5'd0,64'd0);
    for (int i = 0; i < 32; i++) refMem[i] = '0;
    owner = 0; lockRun = 0; lastWin = 2; pendA = 0; pendB = 0;
    pendAData = '0; pendBData = '0;
    rst_n = 0; a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;

    vecs[0]  = '{mk(0, 1,1,0,5'd3,64'h11, 1,0,0,5'd3,64'd0), ex(0,0,0,0,0,0,5'd0,64'd0,64'd0,64'd0)};
    vecs[1]  = '{mk(1, 1,1,0,5'd3,64'h11, 1,0,0,5'd3,64'd0), ex(1,0,0,0,1,0,5'd3,64'h11,64'd0,64'd0)};
    vecs[2]  = '{mk(1, 1,0,0,5'd4,64'd0, 1,0,0,5'd3,64'd0), ex(0,1,0,0,0,0,5'd3,64'd0,64'd0,64'd0)};
    vecs[3]  = '{mk(1, 1,0,0,5'd4,64'd0, 1,1,0,5'd7,64'h22), ex(1,0,0,1,0,0,5'd4,64'd0,64'd0,64'h11)};
    vecs[4]  = '{mk(1, 1,1,0,5'd5,beef, 1,1,0,5'd7,64'h22), ex(0,1,1,0,1,0,5'd7,64'h22,64'd0,64'd0)};
    vecs[5]  = '{mk(1, 1,1,0,5'd5,beef, 0,0,0,5'd0,64'd0), ex(1,0,0,0,1,0,5'd5,beef,64'd0,64'd0)};
    vecs[6]  = '{mk(1, 1,0,0,5'd5,64'd0, 0,0,0,5'd0,64'd0), ex(1,0,0,0,0,0,5'd5,64'd0,64'd0,64'd0)};
    vecs[7]  = '{idle, ex(0,0,1,0,0,0,5'd0,64'd0,beef,64'd0)};
    vecs[8]  = '{mk(1, 0,0,0,5'd0,64'd0, 1,0,0,5'd7,64'd0), ex(0,1,0,0,0,0,5'd7,64'd0,64'd0,64'd0)};
    vecs[9]  = '{idle, ex(0,0,0,1,0,0,5'd0,64'd0,64'd0,64'h22)};
    vecs[10] = '{idle, ex(0,0,0,0,0,0,5'd0,64'd0,64'd0,64'd0)};
    vecs[11] = '{idle, ex(0,0,0,0,0,0,5'd0,64'd0,64'd0,64'd0)};

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), 256'(act), 256'(vecs[i].e));
    end

    $display("[TB] lock hold and release");
    applyStimulus(mk(0, 0,0,0,5'd0,64'd0, 0,0,0,5'd0,64'd0));
    applyStimulus(mk(1, 0,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    checkOutput("lockEnter", 256'({act.aGnt, act.bGnt}), 256'(2'b01));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
      checkOutput("lockHold", 256'({act.aGnt, act.bGnt}), 256'(2'b01));
    end
    applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,0,5'd2,64'd0));
    checkOutput("lockLastB", 256'({act.aGnt, act.bGnt}), 256'(2'b01));
    applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,0,5'd2,64'd0));
    checkOutput("lockRelease", 256'({act.aGnt, act.bGnt}), 256'(2'b10));

    $display("[TB] lock timeout");
    applyStimulus(mk(0, 0,0,0,5'd0,64'd0, 0,0,0,5'd0,64'd0));
    applyStimulus(mk(1, 0,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    checkOutput("toGrant1", 256'({act.aGnt, act.bGnt, act.timeout}), 256'(3'b010));
    for (int g = 2; g <= LOCK_MAX; g++) begin
      applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
      checkOutput($sformatf("toGrant%0d", g), 256'({act.aGnt, act.bGnt, act.timeout}),
                  256'({1'b0, 1'b1, (g == LOCK_MAX)}));
    end
    applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    checkOutput("toAfter", 256'({act.aGnt, act.bGnt, act.timeout}), 256'(3'b100));

    $display("[TB] reset during lock");
    applyStimulus(mk(0, 0,0,0,5'd0,64'd0, 0,0,0,5'd0,64'd0));
    applyStimulus(mk(1, 0,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    applyStimulus(mk(0, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    checkOutput("rstMidLock", 256'(act), 256'(0));
    applyStimulus(mk(1, 1,0,0,5'd1,64'd0, 1,0,1,5'd2,64'd0));
    checkOutput("rstRelease", 256'({act.aGnt, act.bGnt, act.bRvalid}), 256'(3'b100));

    $display("[TB] randomized traffic against model");
    useModel = 1;
    aBusy = 0; bBusy = 0;
    rs = idle;
    for (int c = 0; c < 600; c++) begin
      rs.rstN = ($urandom_range(0, 99) != 0);
      if (!aBusy) begin
        rs.aReq = ($urandom_range(0, 2) != 0); rs.aWe = $urandom_range(0, 1) == 1;
        rs.aLock = ($urandom_range(0, 3) != 0); rs.aAddr = 5'($urandom_range(0, 7));
        rs.aWdata = {$urandom, $urandom};
      end
      if (!bBusy) begin
        rs.bReq = ($urandom_range(0, 2) != 0); rs.bWe = $urandom_range(0, 1) == 1;
        rs.bLock = ($urandom_range(0, 3) != 0); rs.bAddr = 5'($urandom_range(0, 7));
        rs.bWdata = {$urandom, $urandom};
      end
      applyStimulus(rs);
      aBusy = rs.aReq && !act.aGnt;
      bBusy = rs.bReq && !act.bGnt;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of words in the shared memory.
REQ-002 The block SHALL have parameter BITS, default 64, giving the data word width.
REQ-003 The block SHALL have parameter LOCK_MAX, default 16, giving the maximum number of consecutive locked grants.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 a_req, a_we, a_lock  in  1 each  requester A: access request, write select, lock request.
REQ-007 a_addr  in  $clog2(DEPTH)  requester A word address.
REQ-008 a_wdata  in  BITS  requester A write data.
REQ-009 a_gnt, a_rvalid  out  1 each  requester A: access granted this cycle; read data valid.
REQ-010 a_rdata  out  BITS  requester A read data.
REQ-011 b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  SHALL mirror the A ports for requester B.
REQ-012 mem_address  out  $clog2(DEPTH)  shared memory address.
REQ-013 mem_writeData  out  BITS  shared memory write data.
REQ-014 mem_writeEn  out  1  shared memory write enable.
REQ-015 mem_readData  in  BITS  shared memory read data; registered on posedge, so 1-cycle latency.
REQ-016 lock_timeout  out  1  one-cycle pulse when a lock is forcibly broken.

Function
REQ-017 At most one of a_gnt and b_gnt SHALL be high in any cycle.
REQ-018 Grants SHALL be combinational from the req inputs and registered state, within the same cycle.
REQ-019 A requester SHALL hold req, we, addr, wdata and lock stable until it sees gnt; one grant serves exactly one access.
REQ-020 In a grant cycle, mem_address and mem_writeData SHALL come from the granted requester, and mem_writeEn SHALL equal that requester's we.
REQ-021 With no grant, mem_address, mem_writeData and mem_writeEn SHALL all be 0.
REQ-022 Writes commit at the negedge of the grant cycle, so a read granted in any later cycle returns the new data.
REQ-023 For a read grant in cycle N, x_rvalid SHALL be high in cycle N+1 only, and x_rdata SHALL equal mem_readData in that cycle.
REQ-024 x_rdata SHALL be 0 whenever x_rvalid is low.
REQ-025 The FSM SHALL have three states: ARB, LOCK_A and LOCK_B.
REQ-026 In ARB with only one req high, that requester SHALL be granted.
REQ-027 In ARB with both req high, the requester not named by the last-grant pointer `last` SHALL be granted, and `last` SHALL update on every grant.
REQ-028 In ARB, a grant with x_lock high SHALL move the FSM to LOCK_x and load the lock counter with 1.
REQ-029 In LOCK_x, only requester x SHALL be granted, and the other requester SHALL wait regardless of its req.
REQ-030 LOCK_x SHALL return to ARB after a granted cycle with x_lock low, or after any cycle with x_req low.
REQ-031 In LOCK_x, each granted cycle with x_lock high SHALL increment the counter.
REQ-032 When the counter reaches LOCK_MAX, that grant SHALL still be served, lock_timeout SHALL pulse in the same cycle, the FSM SHALL go to ARB, and `last` SHALL be set to x.
REQ-033 The counter SHALL saturate and never wrap.

Reset
REQ-034 While rst_n is low, the following SHALL be 0: all gnt, all rvalid, all rdata, mem_writeEn, mem_address, mem_writeData and lock_timeout.
REQ-035 While rst_n is low, the state SHALL be ARB, the counter SHALL be 0 and `last` SHALL be B, so A wins the first tie.
REQ-036 Reset asserted mid-operation SHALL immediately drop any lock and cancel any pending rvalid.
REQ-037 The first grant SHALL be possible in the first cycle in which rst_n is high.

Verification
REQ-038 Write then read: A writes 0xDEADBEEF to addr 5 in cycle 1, then reads addr 5 in cycle 2 -> a_rvalid high in cycle 3 with a_rdata=0xDEADBEEF.
REQ-039 Round-robin: a_req and b_req both held high for 4 cycles after reset -> grants go A,B,A,B, with mem_writeEn high only in cycles whose granted we=1.
REQ-040 Lock: B granted with b_lock=1 for 3 cycles while a_req is held high -> a_gnt stays 0, and a_gnt=1 in the cycle after b_lock falls.
REQ-041 Timeout: B holds lock and req for 20 cycles with LOCK_MAX=16 -> lock_timeout pulses on the 16th grant and A is granted the next cycle.
REQ-042 Reset mid-lock: rst_n pulsed low during LOCK_B with a read pending -> b_rvalid=0, state ARB, and A wins the first tie after release.
REQ-043 Idle: no req for 5 cycles -> no gnt, mem_writeEn=0, mem_address=0, and no rvalid.
